// File: rtl/wb_burst_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_burst_pkg : shared encodings and default widths for wb_burst_master   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package wb_burst_pkg;

  localparam int unsigned c_AW_DEFAULT      = 32;
  localparam int unsigned c_DW_DEFAULT      = 32;
  localparam int unsigned c_LW_DEFAULT      = 4;
  localparam int unsigned c_TIMEOUT_DEFAULT = 64;
  localparam int unsigned c_RETRIES_DEFAULT = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WDAT = 3'd1,
    S_STRB = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_ERR     = 2'b01;
  localparam status_t ST_TIMEOUT = 2'b10;

  // Width needed to hold values 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_timeout_cnt : watchdog counter, flags terminal count at TIMEOUT-1     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned       c_CW   = $clog2(TIMEOUT);
  localparam logic [c_CW-1:0]   c_TERM = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] cnt_q;
  logic [c_CW-1:0] cnt_d;

  // Holds at the terminal value so the flag cannot wrap away.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + c_CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == c_TERM);

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_burst_master : Wishbone classic burst master with ERR retry, ACK      |
// |                   watchdog and sticky interrupt flag                     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int unsigned AW      = c_AW_DEFAULT,
  parameter int unsigned DW      = c_DW_DEFAULT,
  parameter int unsigned SW      = DW / 8,
  parameter int unsigned LW      = c_LW_DEFAULT,
  parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT,
  parameter int unsigned RETRIES = c_RETRIES_DEFAULT
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [LW-1:0] cmd_len,
  input  logic [SW-1:0] cmd_sel,
  input  logic [DW-1:0] wd_data,
  input  logic          wd_valid,
  output logic          wd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic [1:0]    status,
  input  logic          INTR_I,
  output logic          irq_pending,
  input  logic          irq_clr,
  output logic [AW-1:0] ADR_O,
  output logic [DW-1:0] DAT_O,
  input  logic [DW-1:0] DAT_I,
  output logic          WE_O,
  output logic [SW-1:0] SEL_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic          ACK_I,
  input  logic          ERR_I
);

  localparam int unsigned      c_RW         = cnt_width(RETRIES + 1);
  localparam logic [c_RW-1:0]  c_RETRY_LOAD = c_RW'(RETRIES);
  localparam logic [AW-1:0]    c_ADR_STEP   = AW'(SW);

  state_e          state_q;
  logic [LW-1:0]   beats_q;
  logic [c_RW-1:0] retry_q;
  logic            cmd_ready_q;
  logic            wd_ready_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic            done_q;
  status_t         status_q;
  logic            irq_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic            we_q;
  logic [SW-1:0]   sel_q;
  logic            stb_q;
  logic            cyc_q;

  logic w_to_clr;
  logic w_to_en;
  logic w_to_tc;

  // Watchdog restarts for every strobe attempt, including back-to-back reads.
  assign w_to_en  = (state_q == S_STRB);
  assign w_to_clr = (state_q != S_STRB) || ACK_I || ERR_I;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_watchdog (
    .clk_i  (CLK_I),
    .rst_ni (RST_I),
    .clr_i  (w_to_clr),
    .en_i   (w_to_en),
    .tc_o   (w_to_tc)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= S_IDLE;
      beats_q     <= '0;
      retry_q     <= '0;
      cmd_ready_q <= 1'b0;
      wd_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wd_ready_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            adr_q       <= cmd_adr;
            we_q        <= cmd_we;
            sel_q       <= cmd_sel;
            beats_q     <= cmd_len;
            retry_q     <= c_RETRY_LOAD;
            cyc_q       <= 1'b1;
            if (cmd_we) begin
              state_q <= S_WDAT;
            end else begin
              stb_q   <= 1'b1;
              state_q <= S_STRB;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_WDAT: begin
          if (wd_valid) begin
            dat_q   <= wd_data;
            stb_q   <= 1'b1;
            state_q <= S_STRB;
          end
        end
        S_STRB: begin
          // ERR wins over a simultaneous ACK.
          if (ERR_I) begin
            if (retry_q != '0) begin
              retry_q <= retry_q - c_RW'(1);
              stb_q   <= 1'b0;
              state_q <= S_GAP;
            end else begin
              cyc_q    <= 1'b0;
              stb_q    <= 1'b0;
              done_q   <= 1'b1;
              status_q <= ST_ERR;
              state_q  <= S_FIN;
            end
          end else if (ACK_I) begin
            if (we_q) begin
              wd_ready_q <= 1'b1;
            end else begin
              rd_data_q  <= DAT_I;
              rd_valid_q <= 1'b1;
            end
            if (beats_q == '0) begin
              cyc_q    <= 1'b0;
              stb_q    <= 1'b0;
              done_q   <= 1'b1;
              status_q <= ST_OK;
              state_q  <= S_FIN;
            end else begin
              adr_q   <= adr_q + c_ADR_STEP;
              beats_q <= beats_q - LW'(1);
              retry_q <= c_RETRY_LOAD;
              if (we_q) begin
                stb_q   <= 1'b0;
                state_q <= S_WDAT;
              end
            end
          end else if (w_to_tc) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            done_q   <= 1'b1;
            status_q <= ST_TIMEOUT;
            state_q  <= S_FIN;
          end
        end
        S_GAP: begin
          stb_q   <= 1'b1;
          state_q <= S_STRB;
        end
        S_FIN: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A same-cycle set beats the clear so no interrupt edge is lost.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      irq_q <= 1'b0;
    end else if (INTR_I) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wd_ready    = wd_ready_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign status      = status_q;
  assign irq_pending = irq_q;
  assign ADR_O       = adr_q;
  assign DAT_O       = dat_q;
  assign WE_O        = we_q;
  assign SEL_O       = sel_q;
  assign STB_O       = stb_q;
  assign CYC_O       = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_burst_master : scoreboard bench for wb_burst_master                |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_wb_burst_master;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [11:0] cmd_adr = '0;
  logic [3:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] wd_data;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic [1:0]  status;
  logic        INTR_I = 1'b0;
  logic        irq_pending;
  logic        irq_clr = 1'b0;
  logic [11:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        WE_O;
  logic [3:0]  SEL_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;
  logic        ERR_I;

  wb_burst_master #(
    .AW(12), .DW(32), .SW(4), .LW(4), .TIMEOUT(64), .RETRIES(2)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .status(status),
    .INTR_I(INTR_I), .irq_pending(irq_pending), .irq_clr(irq_clr),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE_O(WE_O), .SEL_O(SEL_O),
    .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  function automatic logic [31:0] wdat(input int i);
    return 32'hCAFE_0000 | 32'(i);
  endfunction

  // Slave: registered response one cycle after seeing a fresh strobe.
  int err_used = 0;
  int err_base = 0;
  int err_n    = 0;
  bit both     = 1'b0;
  bit no_resp  = 1'b0;

  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ACK_I <= 1'b0;
      ERR_I <= 1'b0;
      DAT_I <= '0;
    end else if (CYC_O && STB_O && !ACK_I && !ERR_I && !no_resp) begin
      if ((err_used - err_base) < err_n) begin
        ERR_I    <= 1'b1;
        ACK_I    <= both;
        err_used <= err_used + 1;
      end else begin
        ACK_I <= 1'b1;
        DAT_I <= {20'h0, ADR_O ^ 12'h1F0};
      end
    end else begin
      ACK_I <= 1'b0;
      ERR_I <= 1'b0;
    end
  end

  // Host write-data source: advances when a beat is reported consumed.
  int wd_idx = 0;
  assign wd_data = wdat(wd_idx);
  always @(negedge CLK_I) if (wd_ready) wd_idx++;

  typedef struct {
    logic [11:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  bus_t        q_bus[$];
  logic [31:0] q_rd[$];
  logic [1:0]  q_done[$];

  int tick = 0, stb_rise = 0, cyc_run = 0, gap_run = 0;
  int last_cyc = 0, last_gap = 0, last_lat = 0;
  int done_cnt = 0, rd_cnt = 0;
  bit stb_prev = 1'b0, cyc_prev = 1'b0;

  always @(negedge CLK_I) begin
    bus_t e;
    logic [31:0] r;
    logic [1:0]  s;
    tick++;
    if (STB_O && !stb_prev) stb_rise = tick;
    stb_prev = STB_O;
    if (CYC_O) begin
      if (!cyc_prev) begin
        cyc_run = 0;
        gap_run = 0;
      end
      cyc_run++;
      if (!STB_O) gap_run++;
    end
    cyc_prev = CYC_O;
    if (CYC_O && STB_O && (ACK_I || ERR_I)) begin
      if (q_bus.size() == 0) chk("bus_extra", 32'(ADR_O), 32'hFFFF_FFFF);
      else begin
        e = q_bus.pop_front();
        chk("bus_adr", 32'(ADR_O), 32'(e.adr));
        chk("bus_we", 32'(WE_O), 32'(e.we));
        if (e.we) chk("bus_dat", DAT_O, e.dat);
      end
    end
    if (rd_valid) begin
      rd_cnt++;
      if (q_rd.size() == 0) chk("rd_extra", rd_data, 32'hFFFF_FFFF);
      else begin
        r = q_rd.pop_front();
        chk("rd_data", rd_data, r);
      end
    end
    if (done) begin
      done_cnt++;
      last_cyc = cyc_run;
      last_gap = gap_run;
      last_lat = tick - stb_rise;
      chk("done_cyc_low", 32'(CYC_O), 32'd0);
      if (q_done.size() == 0) chk("done_extra", 32'(status), 32'hFFFF_FFFF);
      else begin
        s = q_done.pop_front();
        chk("status", 32'(status), 32'(s));
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [11:0] adr, input logic [3:0] len);
    int n = 0;
    @(negedge CLK_I);
    while (!cmd_ready && n < 200) begin
      @(negedge CLK_I);
      n++;
    end
    chk("cmd_ready_wait", 32'(n < 200), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = len;
    cmd_sel   = 4'hF;
    @(negedge CLK_I);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < lim) begin
      @(negedge CLK_I);
      #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt != start), 32'd1);
  endtask

  task automatic push_bus(input logic [11:0] adr, input logic we, input logic [31:0] dat);
    bus_t e;
    e.adr = adr;
    e.we  = we;
    e.dat = dat;
    q_bus.push_back(e);
  endtask

  initial begin
    int i0;
    int dn;
    wd_valid = 1'b1;
    #2 RST_I = 1'b0;
    #1;
    chk("rst_cyc", 32'(CYC_O), 32'd0);
    chk("rst_stb", 32'(STB_O), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_irq", 32'(irq_pending), 32'd0);
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single read: 0x100 ^ 0x1F0 = 0x0F0.
    push_bus(12'h100, 1'b0, '0);
    q_rd.push_back(32'h0000_00F0);
    q_done.push_back(2'b00);
    send_cmd(1'b0, 12'h100, 4'd0);
    wait_done(100);
    chk("rd1_cyc_cycles", 32'(last_cyc), 32'd2);
    chk("rd1_gaps", 32'(last_gap), 32'd0);

    // Write burst of 4 crossing 0x200.
    i0 = wd_idx;
    push_bus(12'h1FC, 1'b1, wdat(i0));
    push_bus(12'h200, 1'b1, wdat(i0 + 1));
    push_bus(12'h204, 1'b1, wdat(i0 + 2));
    push_bus(12'h208, 1'b1, wdat(i0 + 3));
    q_done.push_back(2'b00);
    send_cmd(1'b1, 12'h1FC, 4'd3);
    wait_done(200);
    chk("wr_wd_ready_pulses", 32'(wd_idx - i0), 32'd4);
    chk("wr_gaps", 32'(last_gap), 32'd4);
    chk("wr_cyc_cycles", 32'(last_cyc), 32'd12);

    // Read burst wrapping the 12-bit space, interrupt pulsed mid-burst.
    push_bus(12'hFF8, 1'b0, '0);
    push_bus(12'hFFC, 1'b0, '0);
    push_bus(12'h000, 1'b0, '0);
    q_rd.push_back(32'h0000_0E08);
    q_rd.push_back(32'h0000_0E0C);
    q_rd.push_back(32'h0000_01F0);
    q_done.push_back(2'b00);
    send_cmd(1'b0, 12'hFF8, 4'd2);
    INTR_I = 1'b1;
    @(negedge CLK_I);
    INTR_I = 1'b0;
    wait_done(200);
    chk("wrap_cyc_cycles", 32'(last_cyc), 32'd6);
    repeat (3) @(negedge CLK_I);
    chk("irq_sticky", 32'(irq_pending), 32'd1);
    irq_clr = 1'b1;
    @(negedge CLK_I);
    irq_clr = 1'b0;
    #1 chk("irq_cleared", 32'(irq_pending), 32'd0);
    INTR_I  = 1'b1;
    irq_clr = 1'b1;
    @(negedge CLK_I);
    INTR_I  = 1'b0;
    irq_clr = 1'b0;
    #1 chk("irq_set_wins", 32'(irq_pending), 32'd1);
    irq_clr = 1'b1;
    @(negedge CLK_I);
    irq_clr = 1'b0;

    // Two ERRs on beat 0 of a 2-beat write, then success.
    err_base = err_used;
    err_n    = 2;
    i0 = wd_idx;
    push_bus(12'h040, 1'b1, wdat(i0));
    push_bus(12'h040, 1'b1, wdat(i0));
    push_bus(12'h040, 1'b1, wdat(i0));
    push_bus(12'h044, 1'b1, wdat(i0 + 1));
    q_done.push_back(2'b00);
    send_cmd(1'b1, 12'h040, 4'd1);
    wait_done(200);
    chk("retry_gaps", 32'(last_gap), 32'd4);
    chk("retry_cyc_cycles", 32'(last_cyc), 32'd12);
    chk("retry_wd_ready", 32'(wd_idx - i0), 32'd2);

    // Three ERR+ACK responses exhaust retries; beat 1 never issued.
    err_base = err_used;
    err_n    = 3;
    both     = 1'b1;
    push_bus(12'h100, 1'b0, '0);
    push_bus(12'h100, 1'b0, '0);
    push_bus(12'h100, 1'b0, '0);
    q_done.push_back(2'b01);
    send_cmd(1'b0, 12'h100, 4'd1);
    wait_done(200);
    chk("errx_gaps", 32'(last_gap), 32'd2);
    both  = 1'b0;
    err_n = 0;

    // Silent slave: watchdog fires 64 cycles after STB_O rises.
    no_resp = 1'b1;
    q_done.push_back(2'b10);
    send_cmd(1'b0, 12'h500, 4'd0);
    wait_done(300);
    chk("timeout_latency", 32'(last_lat), 32'd64);
    no_resp = 1'b0;

    // Reset during beat 1 of a 4-beat read.
    push_bus(12'h200, 1'b0, '0);
    q_rd.push_back(32'h0000_03F0);
    dn = done_cnt;
    i0 = rd_cnt;
    send_cmd(1'b0, 12'h200, 4'd3);
    begin
      int n = 0;
      while (rd_cnt == i0 && n < 100) begin
        @(negedge CLK_I);
        #1;
        n++;
      end
      chk("rst_burst_beat0", 32'(rd_cnt - i0), 32'd1);
    end
    chk("pre_rst_stb", 32'(STB_O), 32'd1);
    RST_I = 1'b0;
    #1;
    chk("async_cyc", 32'(CYC_O), 32'd0);
    chk("async_stb", 32'(STB_O), 32'd0);
    chk("async_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_no_done", 32'(done_cnt - dn), 32'd0);

    chk("sb_bus_empty", 32'(q_bus.size()), 32'd0);
    chk("sb_rd_empty", 32'(q_rd.size()), 32'd0);
    chk("sb_done_empty", 32'(q_done.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
